alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 149 ++++++++++++++
 tb/tb_alu_mc.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic commands and an iterative
// shift-add multiply, with registered result, NZCV flags, busy and done.
module alu_mc #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       exe_cmd,
   input  logic             s_bit,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   output logic [WIDTH-1:0] alu_res,
   output logic [3:0]       status,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      CMD_MOV = 4'd1,
      CMD_ADD = 4'd2,
      CMD_ADC = 4'd3,
      CMD_SUB = 4'd4,
      CMD_SBC = 4'd5,
      CMD_AND = 4'd6,
      CMD_ORR = 4'd7,
      CMD_EOR = 4'd8,
      CMD_MVN = 4'd9,
      CMD_MUL = 4'd10
   } cmd_t;

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             mul_s;

   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic [WIDTH:0]   sum;
   logic             cin;
   logic             arith;
   logic             valid;
   logic             v_new;
   logic [WIDTH-1:0] acc_next;

   // Subtraction reuses the adder as val1 + ~val2 + cin, so the carry out
   // is directly the NOT-borrow flag.
   always_comb begin
      op_b  = val2;
      cin   = 1'b0;
      res   = '0;
      arith = 1'b0;
      valid = 1'b1;
      case (exe_cmd)
         CMD_MOV: res = val2;
         CMD_MVN: res = ~val2;
         CMD_ADD: arith = 1'b1;
         CMD_ADC: begin
            arith = 1'b1;
            cin   = status[1];
         end
         CMD_SUB: begin
            arith = 1'b1;
            op_b  = ~val2;
            cin   = 1'b1;
         end
         CMD_SBC: begin
            arith = 1'b1;
            op_b  = ~val2;
            cin   = status[1];
         end
         CMD_AND: res = val1 & val2;
         CMD_ORR: res = val1 | val2;
         CMD_EOR: res = val1 ^ val2;
         default: valid = 1'b0;
      endcase
      sum = {1'b0, val1} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
      if (arith) res = sum[WIDTH-1:0];
      v_new = (val1[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);
   end

   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         alu_res <= '0;
         status  <= 4'b0000;
         busy    <= 1'b0;
         done    <= 1'b0;
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         mul_s   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (MUL_EN && exe_cmd == CMD_MUL) begin
                     mcand  <= val1;
                     mplier <= val2;
                     acc    <= '0;
                     cnt    <= '0;
                     mul_s  <= s_bit;
                     busy   <= 1'b1;
                     state  <= MUL;
                  end else begin
                     done    <= 1'b1;
                     alu_res <= res;
                     if (s_bit && valid) begin
                        status[3] <= res[WIDTH-1];
                        status[2] <= (res == '0);
                        if (arith) status[1:0] <= {sum[WIDTH], v_new};
                     end
                  end
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               // Final step: the product is taken from acc_next so the result
               // lands in the same cycle busy falls.
               if (cnt == CW'(WIDTH - 1)) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  alu_res <= acc_next;
                  if (mul_s) status[3:2] <= {acc_next[WIDTH-1], acc_next == '0};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: directed vector table, random ops against an
// arithmetic reference model, multiply/reset corner sequences, 8-bit instance.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start = 1'b0;
   logic [3:0]  exe_cmd = '0;
   logic        s_bit = 1'b0;
   logic [31:0] val1 = '0;
   logic [31:0] val2 = '0;
   logic [31:0] alu_res;
   logic [3:0]  status;
   logic        busy;
   logic        done;

   logic        start8 = 1'b0;
   logic [3:0]  cmd8 = '0;
   logic        s8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic [7:0]  res8;
   logic [3:0]  st8;
   logic        busy8;
   logic        done8;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] exp_st;
   logic [3:0] exp_st8;

   alu_mc #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .exe_cmd(exe_cmd), .s_bit(s_bit),
      .val1(val1), .val2(val2), .alu_res(alu_res), .status(status),
      .busy(busy), .done(done)
   );

   alu_mc #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .exe_cmd(cmd8), .s_bit(s8),
      .val1(a8), .val2(b8), .alu_res(res8), .status(st8),
      .busy(busy8), .done(done8)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  st;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: flags from unsigned/signed integer arithmetic on the operands.
   function automatic void model(input int w, input bit mul_en, input int cmd, input bit s,
                                 input longint unsigned a, input longint unsigned b,
                                 input logic [3:0] st_in,
                                 output longint unsigned r, output logic [3:0] st_out);
      longint unsigned mask = (64'd1 << w) - 1;
      longint unsigned half = 64'd1 << (w - 1);
      longint sa, sb, sr;
      longint unsigned ur;
      bit c = st_in[1];
      bit arith = 0, valid = 1, cout = 0;
      int ci, bi;
      sa = (a >= half) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb = (b >= half) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      sr = 0;
      r = 0;
      st_out = st_in;
      case (cmd)
         1:  r = b;
         9:  r = ~b & mask;
         6:  r = a & b;
         7:  r = a | b;
         8:  r = a ^ b;
         10: if (mul_en) r = (a * b) & mask; else valid = 0;
         2, 3: begin
            ci = (cmd == 3) ? int'(c) : 0;
            ur = a + b + longint'(ci);
            r = ur & mask;
            cout = (ur > mask);
            sr = sa + sb + longint'(ci);
            arith = 1;
         end
         4, 5: begin
            bi = (cmd == 5) ? int'(!c) : 0;
            cout = (a >= b + longint'(bi));
            r = (a - b - longint'(bi)) & mask;
            sr = sa - sb - longint'(bi);
            arith = 1;
         end
         default: valid = 0;
      endcase
      if (!valid) r = 0;
      if (valid && s) begin
         st_out[3] = (r >= half);
         st_out[2] = (r == 0);
         if (arith) begin
            st_out[1] = cout;
            st_out[0] = (sr > longint'(half) - 1) || (sr < -longint'(half));
         end
      end
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input int cmd, input bit s, input logic [31:0] a, input logic [31:0] b);
      longint unsigned er;
      logic [3:0] es;
      int cyc;
      bit busy_ok;
      model(32, 1'b1, cmd, s, 64'(a), 64'(b), exp_st, er, es);
      @(negedge clk);
      start = 1'b1; exe_cmd = cmd[3:0]; s_bit = s; val1 = a; val2 = b;
      @(posedge clk); #1;
      start = 1'b0;
      if (cmd == 10) begin
         chk("mul_busy_rise", 64'(busy), 64'd1);
         chk("mul_no_early_done", 64'(done), 64'd0);
         cyc = 0;
         busy_ok = 1;
         while (!done && cyc < 40) begin
            // Competing start and changing operands must not disturb the product.
            start = (cyc == 4);
            exe_cmd = (cyc == 4) ? 4'd2 : cmd[3:0];
            val1 = $urandom;
            val2 = $urandom;
            @(posedge clk); #1;
            cyc++;
            if (!done && !busy) busy_ok = 0;
         end
         start = 1'b0;
         chk("mul_latency", 64'(cyc), 64'd32);
         chk("mul_busy_held", 64'(busy_ok), 64'd1);
      end
      chk("op_done", 64'(done), 64'd1);
      chk("op_busy_low", 64'(busy), 64'd0);
      chk("op_res", 64'(alu_res), 64'(er));
      chk("op_status", 64'(status), 64'(es));
      exp_st = es;
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(done), 64'd0);
   endtask

   task automatic run8(input int cmd, input bit s, input logic [7:0] a, input logic [7:0] b);
      longint unsigned er;
      logic [3:0] es;
      model(8, 1'b0, cmd, s, 64'(a), 64'(b), exp_st8, er, es);
      @(negedge clk);
      start8 = 1'b1; cmd8 = cmd[3:0]; s8 = s; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("w8_done", 64'(done8), 64'd1);
      chk("w8_busy", 64'(busy8), 64'd0);
      chk("w8_res", 64'(res8), 64'(er));
      chk("w8_status", 64'(st8), 64'(es));
      exp_st8 = es;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pulse_seen;
      int c;

      tbl[0]  = '{4'd2,  1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
      tbl[1]  = '{4'd4,  1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110};
      tbl[2]  = '{4'd5,  1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0110};
      tbl[3]  = '{4'd3,  1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b0110};
      tbl[4]  = '{4'd3,  1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b0110};
      tbl[5]  = '{4'd1,  1'b1, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 4'b1010};
      tbl[6]  = '{4'd9,  1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0110};
      tbl[7]  = '{4'd6,  1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 4'b0010};
      tbl[8]  = '{4'd7,  1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0010};
      tbl[9]  = '{4'd8,  1'b1, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000, 4'b0110};
      tbl[10] = '{4'd0,  1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      tbl[11] = '{4'd15, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      tbl[12] = '{4'd4,  1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000};
      tbl[13] = '{4'd5,  1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 4'b0010};
      tbl[14] = '{4'd4,  1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
      tbl[15] = '{4'd3,  1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 4'b0000};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_res", 64'(alu_res), 64'd0);
      chk("rst_status", 64'(status), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_res8", 64'(res8), 64'd0);
      chk("rst_status8", 64'(st8), 64'd0);

      // Back-to-back directed vectors; start stays high from the first edge after reset.
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i != 0) @(negedge clk);
         start = 1'b1; exe_cmd = tbl[i].cmd; s_bit = tbl[i].s;
         val1 = tbl[i].a; val2 = tbl[i].b;
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_done", i), 64'(done), 64'd1);
         chk($sformatf("tbl%0d_res", i), 64'(alu_res), 64'(tbl[i].res));
         chk($sformatf("tbl%0d_status", i), 64'(status), 64'(tbl[i].st));
      end
      start = 1'b0;
      exp_st = 4'b0000;
      @(posedge clk); #1;
      chk("tbl_done_clear", 64'(done), 64'd0);

      // Directed multiply with a competing start mid-operation
      run_op(10, 1'b0, 32'h0001_0003, 32'h0002_0005);
      chk("mul_const", 64'(alu_res), 64'h0000_000B_000F);

      for (int i = 0; i < 150; i++)
         run_op(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), pick32(), pick32());

      // Reset in the middle of a multiply
      run_op(1, 1'b1, 32'h0, 32'h8000_0001);
      @(negedge clk);
      start = 1'b1; exe_cmd = 4'd10; s_bit = 1'b1; val1 = 32'h0000_1234; val2 = 32'h0000_5678;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("abort_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_res", 64'(alu_res), 64'd0);
      chk("abort_status", 64'(status), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      pulse_seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done || busy) pulse_seen = 1;
      end
      chk("abort_quiet", 64'(pulse_seen), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1; exe_cmd = 4'd6; s_bit = 1'b1; val1 = 32'h0000_F0F0; val2 = 32'h0000_0FF0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("post_rst_done", 64'(done), 64'd1);
      chk("post_rst_res", 64'(alu_res), 64'h00F0);
      chk("post_rst_status", 64'(status), 64'd0);
      c = 0;
      while (c < 40) begin
         @(posedge clk); #1;
         if (done) pulse_seen = 1;
         c++;
      end
      chk("no_stale_mul_done", 64'(pulse_seen), 64'd0);
      exp_st = 4'b0000;

      // 8-bit instance without multiply
      exp_st8 = 4'b0000;
      run8(2, 1'b1, 8'hFF, 8'h01);
      chk("w8_add_res", 64'(res8), 64'h00);
      chk("w8_add_status", 64'(st8), 64'b0110);
      run8(12, 1'b1, 8'h12, 8'h34);
      chk("w8_cmd12_status", 64'(st8), 64'b0110);
      run8(10, 1'b1, 8'h03, 8'h05);
      chk("w8_mul_disabled", 64'(res8), 64'h00);
      for (int i = 0; i < 60; i++)
         run8(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
